// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Hazard control for a five-stage in-order pipeline. It produces the
// stall, bubble and flush controls from the current hazard inputs.
// Resolution priority: memory stall, then taken branch, then the flush
// shadow left by a taken branch, then an unforwarded data hazard.
// The stall, bubble and flush outputs are combinational, so they act in
// the same cycle as the hazard. The state output is a registered record
// of the cause that was handled in the previous cycle.
// A wait counter tracks how long a memory stall lasts. It raises the
// sticky mem_timeout_err once the stall reaches MEM_TIMEOUT cycles.
// Optional build macro: HAZARD_PERF_CNT_EN adds 32-bit wrapping cycle
// counters for data stalls, memory stalls and branch flushes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | previous cycle had no hazard (also the state after reset)
// DATA_STALL | previous cycle held IF/ID for an unforwarded source
// MEM_WAIT   | previous cycle froze IF..MEMEX waiting on memory
// FLUSH      | previous cycle flushed for a branch or its fetch shadow

module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic       rs1_match_ID,
    input  logic       rs2_match_ID,
    input  logic       rs1_data_forwarded,
    input  logic       rs2_data_forwarded,
    input  logic       branch_taken_EX,
    input  logic       mem_req_MEMEX,
    input  logic       mem_ready,
    output logic       stall_IF,
    output logic       stall_ID,
    output logic       stall_EX,
    output logic       stall_MEMPREP,
    output logic       stall_MEMEX,
    output logic       bubble_EX,
    output logic       bubble_WB,
    output logic       flush_IF,
    output logic       flush_ID,
    output logic [1:0] state,
    output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] data_stall_cnt,
    output logic [31:0] mem_stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DATA_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    hz_state_t   state_q;
    hz_state_t   cause;
    logic        flush_pending;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    logic        mem_stall;
    logic        rs1_hz;
    logic        rs2_hz;
    logic        data_hz;
    logic        data_stall_active;

    assign mem_stall = mem_req_MEMEX & ~mem_ready;
    assign rs1_hz    = rs1_used_ID & rs1_match_ID & ~rs1_data_forwarded;
    assign rs2_hz    = rs2_used_ID & rs2_match_ID & ~rs2_data_forwarded;
    assign data_hz   = rs1_hz | rs2_hz;

    // A data stall is counted only when nothing of higher priority wins.
    assign data_stall_active = ~rst & ~mem_stall & ~branch_taken_EX &
                               ~flush_pending & data_hz;

    // Saturating increment, so a long stall never wraps back below the limit.
    assign wait_cnt_inc = (wait_cnt >= TIMEOUT_VAL) ? wait_cnt
                                                    : wait_cnt + 16'd1;

    assign state = state_q;

    // Prioritised hazard decode. Every control is driven from the current inputs.
    always_comb begin
        stall_IF      = 1'b0;
        stall_ID      = 1'b0;
        stall_EX      = 1'b0;
        stall_MEMPREP = 1'b0;
        stall_MEMEX   = 1'b0;
        bubble_EX     = 1'b0;
        bubble_WB     = 1'b0;
        flush_IF      = 1'b0;
        flush_ID      = 1'b0;
        cause         = RUN;
        if (rst) begin
            // Fill the pipe with NOPs while in reset, whatever the inputs say.
            flush_IF  = 1'b1;
            flush_ID  = 1'b1;
            bubble_EX = 1'b1;
            bubble_WB = 1'b1;
            cause     = RUN;
        end else if (mem_stall) begin
            // Freeze everything up to MEMEX. A branch held in the frozen EX
            // is acted on once memory completes.
            stall_IF      = 1'b1;
            stall_ID      = 1'b1;
            stall_EX      = 1'b1;
            stall_MEMPREP = 1'b1;
            stall_MEMEX   = 1'b1;
            bubble_WB     = 1'b1;
            cause         = MEM_WAIT;
        end else if (branch_taken_EX) begin
            flush_IF  = 1'b1;
            flush_ID  = 1'b1;
            bubble_EX = 1'b1;
            cause     = FLUSH;
        end else if (flush_pending) begin
            // The synchronous fetch returns one more wrong-path word; discard
            // it. Any data hazard it appears to raise is not real.
            flush_IF = 1'b1;
            cause    = FLUSH;
        end else if (data_hz) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_EX = 1'b1;
            cause     = DATA_STALL;
        end
    end

    // Registered cause of the cycle and the branch fetch-shadow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            flush_pending <= 1'b0;
        end else begin
            state_q <= cause;
            if (mem_stall) begin
                flush_pending <= flush_pending;
            end else if (branch_taken_EX) begin
                flush_pending <= 1'b1;
            end else begin
                flush_pending <= 1'b0;
            end
        end
    end

    // Memory wait counter and the sticky timeout flag. Stalling continues past the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt        <= 16'd0;
            mem_timeout_err <= 1'b0;
        end else if (mem_stall) begin
            wait_cnt <= wait_cnt_inc;
            if (wait_cnt_inc == TIMEOUT_VAL) begin
                mem_timeout_err <= 1'b1;
            end
        end else begin
            wait_cnt <= 16'd0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running performance counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_stall_cnt <= 32'd0;
            mem_stall_cnt  <= 32'd0;
            flush_cnt      <= 32'd0;
        end else begin
            if (data_stall_active) begin
                data_stall_cnt <= data_stall_cnt + 32'd1;
            end
            if (mem_stall) begin
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
            end
            if (flush_ID) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 1023: MEM_WAIT cycle count at which mem_timeout_err sets; legal range 1..65535.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rs1_used_ID, rs2_used_ID  in  1  ID instruction reads rs1/rs2; 0 for bubbles.
REQ-005 rs1_match_ID, rs2_match_ID  in  1  ID source equals an enabled, nonzero rd in EX..WB.
REQ-006 rs1_data_forwarded, rs2_data_forwarded  in  1  forwarding network supplied that source's value.
REQ-007 branch_taken_EX  in  1  EX resolved a taken branch or jump this cycle.
REQ-008 mem_req_MEMEX  in  1  MEMEX holds a load/store; mem_ready  in  1  memory completes this cycle.
REQ-009 stall_IF, stall_ID, stall_EX, stall_MEMPREP, stall_MEMEX  out  1  hold that stage's register.
REQ-010 bubble_EX, bubble_WB  out  1  load NOP into EX / WB.
REQ-011 flush_IF, flush_ID  out  1  replace IF/ID contents with NOP.
REQ-012 state  out  2  RUN=0, DATA_STALL=1, MEM_WAIT=2, FLUSH=3.
REQ-013 mem_timeout_err  out  1  sticky memory-timeout flag.

Function
REQ-014 mem_stall = mem_req_MEMEX & ~mem_ready; data_hz = (rs1_used_ID & rs1_match_ID & ~rs1_data_forwarded) | (same for rs2).
REQ-015 Stall/bubble/flush outputs SHALL be combinational from current inputs and flush_pending, same cycle, no added latency.
REQ-016 Priority SHALL be mem_stall > taken branch > flush_pending > data_hz.
REQ-017 mem_stall: stall_IF..stall_MEMEX=1, bubble_WB=1, all else 0; branch_taken_EX SHALL be ignored (EX frozen, input held).
REQ-018 Taken branch without mem_stall: flush_IF=flush_ID=1, bubble_EX=1, stalls 0; flush_pending set next cycle.
REQ-019 flush_pending set, no mem_stall, no new branch: flush_IF=1 only (synchronous-fetch shadow), data_hz ignored; flush_pending cleared next cycle.
REQ-020 flush_pending under mem_stall SHALL be held, not consumed.
REQ-021 data_hz alone: stall_IF=stall_ID=1, bubble_EX=1, later stages advance.
REQ-022 None active: all outputs 0.
REQ-023 state register SHALL load the cause of the current cycle (MEM_WAIT, FLUSH for branch or pending flush, DATA_STALL, else RUN) at each edge.
REQ-024 16-bit wait counter SHALL clear on any cycle without mem_stall and increment during mem_stall, saturating at MEM_TIMEOUT.
REQ-025 mem_timeout_err SHALL set the edge the counter reaches MEM_TIMEOUT; cleared only by rst; stalling continues.

Reset
REQ-026 rst=1 SHALL force next state RUN, flush_pending 0, counter 0, mem_timeout_err 0, perf counters 0.
REQ-027 While rst=1 outputs SHALL be flush_IF=flush_ID=1, bubble_EX=bubble_WB=1, all stalls 0, regardless of inputs.
REQ-028 rst mid-MEM_WAIT or mid-FLUSH SHALL discard the pending wait/flush; first post-reset cycle is RUN.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: adds outputs data_stall_cnt, mem_stall_cnt, flush_cnt (32 each), counting cycles with data stall (REQ-021), mem_stall, and flush_ID=1 when rst=0; wrap 0xFFFFFFFF->0.
REQ-030 Macro undefined: those ports and registers absent; all other behaviour identical.

Verification
REQ-031 rs1_used=1, match=1, fwd=0 for 2 cycles -> stall_IF/ID=1, bubble_EX=1 both cycles, state=1,1; fwd=1 -> all 0.
REQ-032 branch_taken_EX pulse at cycle N -> flush_IF/ID=1, bubble_EX=1 at N; flush_IF only at N+1; state=3 after edges N, N+1.
REQ-033 mem_req=1, mem_ready=0 for 3 cycles, branch_taken_EX held -> stalls IF..MEMEX, bubble_WB=1, no flush; ready at cycle 4 -> flush_IF/ID at 4, flush_IF at 5.
REQ-034 MEM_TIMEOUT=4, mem_ready=0 for 6 cycles -> mem_timeout_err rises at 4th edge, stays 1 until rst.
REQ-035 rst pulsed one cycle at flush_pending/MEM_WAIT -> next cycle all outputs 0, state=0, mem_timeout_err=0.
REQ-036 HAZARD_PERF_CNT_EN: 5 data-stall, 3 mem-stall, 1 branch -> counts 5, 3, 1; data_stall_cnt preloaded 0xFFFFFFFF via stall -> wraps to 0.
